// File: rtl/nano_line_mem_pkg.sv
// Shared types and constants for the NanoCore line-wide main memory.
package nano_mem_pkg;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BYTES = 32;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RD,
        RESP
    } host_state_t;

endpackage

// File: rtl/nano_line_mem_if.sv
// Line port bundle and, when NANO_MEM_HOST_PORT_EN is defined, the host word port bundle.
interface nano_line_mem_if;
    import nano_mem_pkg::*;

    logic        i_mm_rden;
    logic        i_mm_wren;
    logic [31:0] i_mm_addr;
    line_t       i_mm_wdata;
    logic        o_mm_gnt;
    line_t       o_mm_rdata;
    logic        o_mm_rvalid;

    modport master (
        output i_mm_rden, i_mm_wren, i_mm_addr, i_mm_wdata,
        input  o_mm_gnt, o_mm_rdata, o_mm_rvalid
    );

    modport slave (
        input  i_mm_rden, i_mm_wren, i_mm_addr, i_mm_wdata,
        output o_mm_gnt, o_mm_rdata, o_mm_rvalid
    );
endinterface

`ifdef NANO_MEM_HOST_PORT_EN
interface nano_host_if;
    logic        i_host_req;
    logic        i_host_we;
    logic [31:0] i_host_addr;
    logic [31:0] i_host_wdata;
    logic [3:0]  i_host_wstrb;
    logic        o_host_ack;
    logic [31:0] o_host_rdata;
    logic [7:0]  o_host_wait_max;

    modport master (
        output i_host_req, i_host_we, i_host_addr, i_host_wdata, i_host_wstrb,
        input  o_host_ack, o_host_rdata, o_host_wait_max
    );

    modport slave (
        input  i_host_req, i_host_we, i_host_addr, i_host_wdata, i_host_wstrb,
        output o_host_ack, o_host_rdata, o_host_wait_max
    );
endinterface
`endif

// File: rtl/nano_line_mem_bank.sv
// One word bank: DEPTH_LINES x 32 synchronous SRAM with byte enables, write-first read port.
module nano_line_bank #(
    parameter int DEPTH_LINES = 1024,
    localparam int IDX_W = $clog2(DEPTH_LINES)
) (
    input  logic             i_clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_LINES];
    logic [31:0] merged;

    // A read in the same cycle as a write must see the new bytes.
    always_comb begin
        merged = mem[addr];
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= merged;
        end
    end

endmodule

// File: rtl/nano_line_mem.sv
// Line-wide main memory: 8 word banks, 2-cycle line reads, optional host word port
// (enabled by defining NANO_MEM_HOST_PORT_EN).
module nano_line_mem import nano_mem_pkg::*; #(
    parameter int DEPTH_LINES = 1024
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    nano_line_mem_if.slave mm
`ifdef NANO_MEM_HOST_PORT_EN
    ,
    nano_host_if.slave     host
`endif
);

    localparam int IDX_W = $clog2(DEPTH_LINES);

    logic                           line_req;
    logic [IDX_W-1:0]               line_idx;
    logic [LINE_WORDS-1:0]          bank_en;
    logic [LINE_WORDS-1:0]          bank_we;
    logic [LINE_WORDS-1:0][3:0]     bank_be;
    logic [IDX_W-1:0]               bank_addr;
    line_t                          bank_wdata;
    line_t                          bank_rdata;
    logic                           vld_p0;
    logic                           vld_p1;
    line_t                          rdata_p1;
    logic                           unused_mm_addr;

    assign line_req       = mm.i_mm_rden | mm.i_mm_wren;
    assign line_idx       = mm.i_mm_addr[5 +: IDX_W];
    assign mm.o_mm_gnt    = line_req;
    assign unused_mm_addr = ^{mm.i_mm_addr[4:0], mm.i_mm_addr[31:5+IDX_W]};

`ifdef NANO_MEM_HOST_PORT_EN
    host_state_t      state;
    logic [2:0]       word_q;
    logic [7:0]       wait_cnt;
    logic [7:0]       wait_max_q;
    logic             ack_q;
    logic [31:0]      host_rdata_q;
    logic             host_go;
    logic [2:0]       host_word;
    logic [IDX_W-1:0] host_idx;
    logic             unused_host_addr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign host_word        = host.i_host_addr[4:2];
    assign host_idx         = host.i_host_addr[5 +: IDX_W];
    assign host_go          = host.i_host_req & ((state == IDLE) | (state == WAIT)) & ~line_req;
    assign unused_host_addr = ^{host.i_host_addr[1:0], host.i_host_addr[31:5+IDX_W]};
`endif

    // Line port owns the banks whenever it requests; the host only gets idle cycles.
    always_comb begin
        bank_addr  = line_idx;
        bank_wdata = mm.i_mm_wdata;
        for (int k = 0; k < LINE_WORDS; k++) begin
            bank_en[k] = line_req;
            bank_we[k] = mm.i_mm_wren;
            bank_be[k] = 4'hF;
        end
`ifdef NANO_MEM_HOST_PORT_EN
        if (host_go) begin
            bank_addr            = host_idx;
            bank_wdata           = {LINE_WORDS{host.i_host_wdata}};
            bank_en[host_word]   = 1'b1;
            bank_we[host_word]   = host.i_host_we;
            bank_be[host_word]   = host.i_host_wstrb;
        end
`endif
    end

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_bank
        nano_line_bank #(.DEPTH_LINES(DEPTH_LINES)) u_bank (
            .i_clk (i_clk),
            .en    (bank_en[k]),
            .we    (bank_we[k]),
            .be    (bank_be[k]),
            .addr  (bank_addr),
            .wdata (bank_wdata[k]),
            .rdata (bank_rdata[k])
        );
    end

    // p0: bank outputs valid; p1: line output register, rvalid two cycles after accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p0 <= mm.i_mm_rden;
            vld_p1 <= vld_p0;
            if (vld_p0) rdata_p1 <= bank_rdata;
        end
    end

    assign mm.o_mm_rdata  = rdata_p1;
    assign mm.o_mm_rvalid = vld_p1;

`ifdef NANO_MEM_HOST_PORT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            word_q       <= '0;
            wait_cnt     <= '0;
            wait_max_q   <= '0;
            ack_q        <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE, WAIT: begin
                    if (!host.i_host_req) begin
                        state <= IDLE;
                    end else if (line_req) begin
                        state    <= WAIT;
                        wait_cnt <= (state == IDLE) ? 8'd1 : sat_inc(wait_cnt);
                    end else begin
                        word_q <= host_word;
                        if (state == IDLE) wait_cnt <= '0;
                        if (host.i_host_we) begin
                            state <= RESP;
                            ack_q <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    host_rdata_q <= bank_rdata[word_q];
                    ack_q        <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (wait_cnt > wait_max_q) wait_max_q <= wait_cnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.o_host_ack      = ack_q;
    assign host.o_host_rdata    = host_rdata_q;
    assign host.o_host_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_nano_line_mem.sv
// Randomised and directed bench for nano_line_mem; host tests run when NANO_MEM_HOST_PORT_EN is defined.
module tb_nano_line_mem;
    import nano_mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct {
        int    due;
        line_t data;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    ecount = 0;
    int    rv_cnt = 0;
    int    ack_cnt = 0;
    exp_t  q[$];
    line_t mem_m [int];

    nano_line_mem_if mm();
`ifdef NANO_MEM_HOST_PORT_EN
    nano_host_if host();
`endif

    nano_line_mem #(.DEPTH_LINES(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .mm      (mm)
`ifdef NANO_MEM_HOST_PORT_EN
        ,
        .host    (host)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % DEPTH);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: requests sampled on the accepting edge; reads see every earlier and same-cycle write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            ecount++;
            if (mm.i_mm_wren) mem_m[line_of(mm.i_mm_addr)] = mm.i_mm_wdata;
            if (mm.i_mm_rden) begin
                exp_t e;
                e.due  = ecount + 1;
                e.data = mem_m.exists(line_of(mm.i_mm_addr)) ? mem_m[line_of(mm.i_mm_addr)] : '0;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_v;
            chk("gnt", 256'(mm.o_mm_gnt), 256'(mm.i_mm_rden | mm.i_mm_wren));
            exp_v = (q.size() > 0) && (q[0].due == ecount);
            chk("rvalid", 256'(mm.o_mm_rvalid), 256'(exp_v));
            if (mm.o_mm_rvalid) rv_cnt++;
            if (exp_v) begin
                chk("rdata", mm.o_mm_rdata, q[0].data);
                void'(q.pop_front());
            end
`ifdef NANO_MEM_HOST_PORT_EN
            if (host.o_host_ack) ack_cnt++;
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic line_req(input bit rd, input bit wr, input logic [31:0] a, input line_t d);
        mm.i_mm_rden  = rd;
        mm.i_mm_wren  = wr;
        mm.i_mm_addr  = a;
        mm.i_mm_wdata = d;
        cyc();
        mm.i_mm_rden = 1'b0;
        mm.i_mm_wren = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid"}, 256'(mm.o_mm_rvalid), 256'(0));
        chk({tag, "_rdata"}, mm.o_mm_rdata, 256'(0));
`ifdef NANO_MEM_HOST_PORT_EN
        chk({tag, "_ack"}, 256'(host.o_host_ack), 256'(0));
        chk({tag, "_hrdata"}, 256'(host.o_host_rdata), 256'(0));
        chk({tag, "_waitmax"}, 256'(host.o_host_wait_max), 256'(0));
`endif
    endtask

`ifdef NANO_MEM_HOST_PORT_EN
    task automatic host_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int exp_lat, input logic [31:0] exp_rd);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        host.i_host_req   = 1'b1;
        host.i_host_we    = we;
        host.i_host_addr  = a;
        host.i_host_wdata = d;
        host.i_host_wstrb = s;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (host.o_host_ack) begin
                got = 1'b1;
                host.i_host_req = 1'b0;
                if (!we) chk("host_rdata", 256'(host.o_host_rdata), 256'(exp_rd));
            end
        end
        host.i_host_req = 1'b0;
        chk("host_ack_latency", 256'(n), 256'(exp_lat));
        if (we && got) begin
            line_t l;
            l = mem_m.exists(line_of(a)) ? mem_m[line_of(a)] : '0;
            for (int b = 0; b < 4; b++)
                if (s[b]) l[a[4:2]][8*b +: 8] = d[8*b +: 8];
            mem_m[line_of(a)] = l;
        end
    endtask
`endif

    initial begin
        line_t       d;
        logic [31:0] a;
        int          c0;

        mm.i_mm_rden  = 1'b0;
        mm.i_mm_wren  = 1'b0;
        mm.i_mm_addr  = '0;
        mm.i_mm_wdata = '0;
`ifdef NANO_MEM_HOST_PORT_EN
        host.i_host_req   = 1'b0;
        host.i_host_we    = 1'b0;
        host.i_host_addr  = '0;
        host.i_host_wdata = '0;
        host.i_host_wstrb = '0;
`endif
        repeat (2) cyc();
        @(negedge clk);
        chk_reset_outputs("reset");
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");
        cyc();

        // Preload lines 0..15 so every later read has a defined model value.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) d[k] = 32'hC000_0000 | (i << 8) | k;
            line_req(1'b0, 1'b1, 32'(i << 5), d);
        end

        // Write then read next cycle: rvalid two cycles after the read.
        for (int k = 0; k < 8; k++) d[k] = 32'h1000_0000 + k;
        line_req(1'b0, 1'b1, 32'h40, d);
        line_req(1'b1, 1'b0, 32'h40, '0);
        @(negedge clk);
        chk("t1_rvalid_early", 256'(mm.o_mm_rvalid), 256'(0));
        @(negedge clk);
        chk("t1_rvalid", 256'(mm.o_mm_rvalid), 256'(1));
        for (int k = 0; k < 8; k++)
            chk("t1_word", 256'(mm.o_mm_rdata[k]), 256'(32'h1000_0000 + k));
        cyc();

        c0 = rv_cnt;
        line_req(1'b1, 1'b0, 32'h00, '0);
        line_req(1'b1, 1'b0, 32'h20, '0);
        line_req(1'b1, 1'b0, 32'h40, '0);
        repeat (3) cyc();
        chk("t2_pulses", 256'(rv_cnt - c0), 256'(3));

        for (int k = 0; k < 8; k++) d[k] = 32'hA5A5_0000 + k;
        line_req(1'b1, 1'b1, 32'h60, d);
        @(negedge clk);
        chk("t3_rvalid_early", 256'(mm.o_mm_rvalid), 256'(0));
        @(negedge clk);
        chk("t3_rvalid", 256'(mm.o_mm_rvalid), 256'(1));
        for (int k = 0; k < 8; k++)
            chk("t3_word", 256'(mm.o_mm_rdata[k]), 256'(32'hA5A5_0000 + k));
        cyc();

`ifdef NANO_MEM_HOST_PORT_EN
        line_req(1'b0, 1'b1, 32'h40, '0);
        host_op(1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0011, 2, 32'h0);
        cyc();
        line_req(1'b1, 1'b0, 32'h40, '0);
        @(negedge clk);
        @(negedge clk);
        chk("host_wr_word1", 256'(mm.o_mm_rdata[1]), 256'(32'h0000_BEEF));
        chk("host_wr_word0", 256'(mm.o_mm_rdata[0]), 256'(32'h0));
        cyc();
        fork
            host_op(1'b0, 32'h44, 32'h0, 4'h0, 8, 32'h0000_BEEF);
            for (int i = 0; i < 5; i++) line_req(1'b1, 1'b0, 32'(i << 5), '0);
        join
        cyc();
        chk("host_wait_max", 256'(host.o_host_wait_max), 256'(5));
        chk("host_ack_count", 256'(ack_cnt), 256'(2));
`endif

        // Reset one cycle after a read accept: the read must vanish.
        line_req(1'b1, 1'b0, 32'h20, '0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        cyc();
        rst_n = 1'b1;
        c0 = rv_cnt;
        repeat (4) cyc();
        chk("midreset_no_rvalid", 256'(rv_cnt - c0), 256'(0));
        chk("midreset_rdata", mm.o_mm_rdata, 256'(0));

        // Random traffic over 16 lines with random offset and aliasing upper bits.
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            a[5 +: IDX_W] = IDX_W'($urandom_range(0, 15));
            for (int k = 0; k < 8; k++) d[k] = $urandom;
            line_req(1'($urandom_range(0, 1)), ($urandom % 3) == 0, a, d);
        end
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
